// File: rtl/mem_pkg.sv
// Shared types and byte-lane helpers for the CPU-side Avalon-MM master.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUS   = 2'b01,
        ST_RDATA = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Illegal size code or an access that straddles its natural alignment.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            SIZE_BYTE: wd = {24'h0, data[7:0]} << {off, 3'b000};
            SIZE_HALF: wd = {16'h0, data[15:0]} << {off[1], 4'b0000};
            SIZE_WORD: wd = data;
            default:   wd = '0;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic sgn, input logic [31:0] data);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] rd;
        sh = data >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? data[31:16] : data[15:0];
        case (size)
            SIZE_BYTE: rd = {{24{sgn & b[7]}}, b};
            SIZE_HALF: rd = {{16{sgn & h[15]}}, h};
            SIZE_WORD: rd = data;
            default:   rd = '0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/avm_lane_align.sv
// Combinational byte-lane alignment: store shift/byte-enables and load extract/extend.
module avm_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sgn,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    // Pure lane mapping; no state.
    always_comb begin
        be        = lane_be(size, offset);
        wdata_out = lane_wdata(size, offset, wdata_in);
        rdata_out = lane_extract(size, offset, sgn, rdata_in);
    end

endmodule

// File: rtl/avalon_mem_master.sv
// CPU-side Avalon-MM initiator: one load/store at a time, lane alignment, optional stall timeout.
module avalon_mem_master
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic        sgn_q,   sgn_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [31:0] tcnt_q,  tcnt_d;

    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic [31:0] tcnt_inc;
    logic        timeout_hit;

    // One aligner serves both paths: live request fields while idle, latched fields afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_size = req_size;
            al_off  = req_addr[1:0];
        end else begin
            al_size = size_q;
            al_off  = addr_q[1:0];
        end
    end

    avm_lane_align u_align (
        .size      (al_size),
        .offset    (al_off),
        .sgn       (sgn_q),
        .wdata_in  (req_wdata),
        .rdata_in  (avm_readdata),
        .be        (al_be),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    // Stall-cycle limit check; disabled when TIMEOUT_CYCLES is zero.
    always_comb begin
        tcnt_inc    = tcnt_q + 32'd1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TIMEOUT_CYCLES);
    end

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        write_d = write_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    write_d = req_write;
                    rdata_d = '0;
                    if (req_bad(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        be_d    = '0;
                        wdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        be_d    = al_be;
                        wdata_d = req_write ? al_wdata : '0;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (avm_waitrequest) begin
                    tcnt_d = tcnt_inc;
                    if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = write_q ? ST_RESP : ST_RDATA;
                end
            end
            ST_RDATA: begin
                rdata_d = al_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; async reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Outputs decode straight from state so reset drops read/write without waiting for an edge.
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        avm_read       = (state_q == ST_BUS) && !write_q;
        avm_write      = (state_q == ST_BUS) &&  write_q;
        avm_address    = {addr_q[31:2], 2'b00};
        avm_writedata  = wdata_q;
        avm_byteenable = be_q;
        rsp_valid      = (state_q == ST_RESP);
        rsp_rdata      = rdata_q;
        rsp_error      = err_q;
    end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Randomized self-checking bench for avalon_mem_master with a byte-array Avalon RAM slave.
module tb_avalon_mem_master;

    localparam int unsigned TO    = 8;
    localparam int          MEMSZ = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    avalon_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // Edge count: at the falling edge after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] smem [MEMSZ];   // slave RAM, written only through the bus
    logic [7:0] rmem [MEMSZ];   // reference memory, written from request semantics

    int nchk  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;
    int stall_req = 0;

    // Expected behaviour of the transaction in flight.
    bit          t_active = 1'b0;
    bit          t_write;
    bit          t_err;
    logic [31:0] t_addr;
    logic [3:0]  t_be;
    logic [31:0] t_wd;
    logic [31:0] t_rdata;
    int          t_A, t_busend, t_resp;

    // Observed response and bus values.
    bit          got_seen;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_cyc;
    logic [31:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Avalon RAM slave: programmable stall, readdata valid only in the cycle after completion.
    initial begin : slave
        int          stall_left;
        bit          prev_active;
        bit          rd_pend;
        logic [31:0] rd_word;
        int          a;
        stall_left      = 0;
        prev_active     = 1'b0;
        rd_pend         = 1'b0;
        rd_word         = '0;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            avm_readdata = rd_pend ? rd_word : $urandom;
            rd_pend      = 1'b0;
            if (avm_read || avm_write) begin
                if (!prev_active) stall_left = stall_req;
                prev_active = 1'b1;
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    a = int'(avm_address) & (MEMSZ - 1);
                    if (avm_write) begin
                        for (int i = 0; i < 4; i++)
                            if (avm_byteenable[i]) smem[a + i] = avm_writedata[8*i +: 8];
                    end else begin
                        rd_word = {smem[a + 3], smem[a + 2], smem[a + 1], smem[a]};
                        rd_pend = 1'b1;
                    end
                end
            end else begin
                prev_active     = 1'b0;
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the expected transaction timeline.
    initial begin : compare
        bit in_bus, busy, is_resp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                in_bus  = t_active && cyc >= t_A && cyc <= t_busend;
                busy    = t_active && cyc >= t_A && cyc <= t_resp;
                is_resp = t_active && cyc == t_resp;
                chk("avm_read",  avm_read,  in_bus && !t_write);
                chk("avm_write", avm_write, in_bus &&  t_write);
                chk("req_ready", req_ready, !busy);
                chk("rsp_valid", rsp_valid, is_resp);
                if (in_bus) begin
                    chk("avm_address",    avm_address,    {t_addr[31:2], 2'b00});
                    chk("avm_byteenable", avm_byteenable, t_be);
                    chk("avm_writedata",  avm_writedata,  t_wd);
                    last_addr = avm_address;
                    last_be   = avm_byteenable;
                    last_wd   = avm_writedata;
                end
                if (rsp_valid) begin
                    got_seen  = 1'b1;
                    got_rdata = rsp_rdata;
                    got_err   = rsp_error;
                    got_cyc   = cyc;
                end
                if (is_resp) begin
                    chk("rsp_rdata", rsp_rdata, t_rdata);
                    chk("rsp_error", rsp_error, t_err);
                end
            end
        end
    end

    // Issue one request; expectations come from byte-level request semantics and the reference memory.
    task automatic do_txn(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] ad, input logic [31:0] wd, input int st);
        int          n, off, a;
        bit          bad, tmo;
        logic [31:0] v;
        off = int'(ad[1:0]);
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00);
        tmo = !bad && st >= int'(TO);
        a   = int'(ad) & (MEMSZ - 1);
        t_be = '0;
        t_wd = '0;
        if (!bad)
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + n) begin
                    t_be[i] = 1'b1;
                    if (w) t_wd[8*i +: 8] = wd[8*(i - off) +: 8];
                end
        v = '0;
        if (!bad && !tmo && !w) begin
            for (int j = 0; j < n; j++) v[8*j +: 8] = rmem[a + j];
            if (sg && n < 4 && v[8*n - 1])
                for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        end
        if (!bad && !tmo && w)
            for (int j = 0; j < n; j++) rmem[a + j] = wd[8*j +: 8];
        t_A     = cyc + 1;
        t_write = w;
        t_addr  = ad;
        t_err   = bad || tmo;
        t_rdata = v;
        if (bad)      begin t_busend = t_A - 1;        t_resp = t_A;                      end
        else if (tmo) begin t_busend = t_A + int'(TO) - 1; t_resp = t_A + int'(TO);       end
        else          begin t_busend = t_A + st;       t_resp = t_A + st + (w ? 1 : 2);   end
        got_seen   = 1'b0;
        got_rdata  = 32'hDEAD_BEEF;
        got_err    = 1'bx;
        got_cyc    = -1;
        stall_req  = bad ? 0 : st;
        t_active   = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_size   = 2'($urandom);
        req_write  = 1'($urandom);
        while (cyc <= t_resp) @(negedge clk);
        #1;
    endtask

    function automatic int lat();
        return got_cyc + 1 - t_A;
    endfunction

    task automatic poke(input int a, input logic [7:0] b);
        smem[a] = b;
        rmem[a] = b;
    endtask

    initial begin : main
        logic [7:0]  b;
        logic [31:0] ad, wd;
        logic [1:0]  sz;
        int          r, st;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < MEMSZ; i++) begin
            b = 8'($urandom);
            poke(i, b);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avm_read",   avm_read,       1'b0);
        chk("rst_avm_write",  avm_write,      1'b0);
        chk("rst_rsp_valid",  rsp_valid,      1'b0);
        chk("rst_rsp_error",  rsp_error,      1'b0);
        chk("rst_address",    avm_address,    32'h0);
        chk("rst_writedata",  avm_writedata,  32'h0);
        chk("rst_rsp_rdata",  rsp_rdata,      32'h0);
        chk("rst_byteenable", avm_byteenable, 4'b0000);
        chk("rst_req_ready",  req_ready,      1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b1;

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        chk("lw_model", t_rdata, 32'h44332211);
        chk("lw_rdata", got_rdata, 32'h44332211);
        chk("lw_be", last_be, 4'b1111);
        chk("lw_latency", lat(), 3);

        poke(32'h103, 8'hF0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0);
        chk("lb_rdata", got_rdata, 32'hFFFF_FFF0);
        chk("lb_be", last_be, 4'b1000);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
        chk("lbu_rdata", got_rdata, 32'h0000_00F0);

        do_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 0);
        chk("sh_address", last_addr, 32'h100);
        chk("sh_be", last_be, 4'b1100);
        chk("sh_writedata", last_wd, 32'hBEEF_0000);
        chk("sh_latency", lat(), 2);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        chk("sh_readback_hi", got_rdata >> 16, 32'h0000_BEEF);

        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5);
        chk("lw_wait5_latency", lat(), 8);
        chk("lw_wait5_rdata", got_rdata, 32'hBEEF_2211);

        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);
        chk("misalign_err", got_err, 1'b1);
        chk("misalign_latency", lat(), 1);
        do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
        chk("size11_err", got_err, 1'b1);
        chk("size11_latency", lat(), 1);

        do_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 50);
        chk("timeout_err", got_err, 1'b1);
        chk("timeout_rdata", got_rdata, 32'h0);
        chk("timeout_latency", lat(), int'(TO) + 1);

        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            ad = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 8) begin
                if (sz == 2'd1) ad[0]   = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            if ($urandom_range(0, 1) == 1) ad = ad | 32'hA000_0000;
            r  = $urandom_range(0, 19);
            st = (r < 12) ? 0 : (r < 17) ? $urandom_range(1, 3) :
                 (r == 17) ? int'(TO) - 1 : (r == 18) ? int'(TO) : int'(TO) + 3;
            wd = $urandom;
            do_txn(1'($urandom), sz, 1'($urandom), ad, wd, st);
        end

        chk_en   = 1'b0;
        t_active = 1'b0;
        @(negedge clk);
        #1;
        stall_req  = 100;
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h200;
        req_valid  = 1'b1;
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !avm_read; k++) @(negedge clk);
        chk("rstbus_read_before", avm_read, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstbus_read_drop", avm_read, 1'b0);
        chk("rstbus_write_low", avm_write, 1'b0);
        chk("rstbus_no_rsp", rsp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstbus_after_rsp", rsp_valid, 1'b0);
            chk("rstbus_after_ready", req_ready, 1'b1);
            chk("rstbus_after_read", avm_read, 1'b0);
        end
        #1;
        stall_req = 0;
        chk_en    = 1'b1;
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1);
        chk("recover_seen", got_seen, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
